// File: rtl/axil_reg_access_arbiter.sv
// Round-robin arbiter and sequencer that shares one AXI4-Lite register port between two
// local requesters, running one single-beat write or read at a time.
module axil_reg_access_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  // Requester side. Handshake: a requester raises REQ_VALID[n] with WE/ADDR/WDATA and holds
  // them until REQ_READY[n] pulses for one cycle, which is the moment the fields are captured;
  // RSP_VALID[n] later pulses once with RSP_RDATA/RSP_RESP. AXI channels use standard
  // valid/ready rules: a VALID stays high with stable payload until the cycle READY is seen.
  input  logic [1:0]                REQ_VALID,
  output logic [1:0]                REQ_READY,
  input  logic [1:0]                REQ_WE,
  input  logic [2*ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [2*DATA_WIDTH-1:0]   REQ_WDATA,
  output logic [1:0]                RSP_VALID,
  output logic [DATA_WIDTH-1:0]     RSP_RDATA,
  output logic [1:0]                RSP_RESP,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic                    last_grant, gnt_q;
  logic                    aw_valid_q, w_valid_q, ar_valid_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;

  logic                    req_any, gnt_sel, sel_we, grant_fire;
  logic                    aw_done, w_done;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // On a tie the requester that was not served last wins; a lone requester always wins.
  assign req_any    = |REQ_VALID;
  assign gnt_sel    = (REQ_VALID == 2'b11) ? ~last_grant : REQ_VALID[1];
  assign sel_we     = REQ_WE[gnt_sel];
  assign sel_addr   = gnt_sel ? REQ_ADDR[ADDR_WIDTH +: ADDR_WIDTH] : REQ_ADDR[0 +: ADDR_WIDTH];
  assign sel_wdata  = gnt_sel ? REQ_WDATA[DATA_WIDTH +: DATA_WIDTH] : REQ_WDATA[0 +: DATA_WIDTH];
  assign grant_fire = (state == IDLE) && req_any;

  // A channel counts as done once its flag has dropped or is dropping this cycle.
  assign aw_done = !aw_valid_q || M_AXI_AWREADY;
  assign w_done  = !w_valid_q  || M_AXI_WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = sel_we ? WR_AW_W : RD_AR;
      WR_AW_W: if (aw_done && w_done) state_nxt = WR_B;
      WR_B:    if (M_AXI_BVALID) state_nxt = RSP;
      RD_AR:   if (M_AXI_ARREADY) state_nxt = RD_R;
      RD_R:    if (M_AXI_RVALID) state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    REQ_READY    = 2'b00;
    RSP_VALID    = 2'b00;
    M_AXI_BREADY = 1'b0;
    M_AXI_RREADY = 1'b0;
    if (grant_fire && ARESETN) REQ_READY = {gnt_sel, ~gnt_sel};
    if (state == RSP)          RSP_VALID = {gnt_q, ~gnt_q};
    if (state == WR_B)         M_AXI_BREADY = 1'b1;
    if (state == RD_R)         M_AXI_RREADY = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      last_grant  <= 1'b1;
      gnt_q       <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      if (grant_fire) begin
        last_grant <= gnt_sel;
        gnt_q      <= gnt_sel;
        addr_q     <= sel_addr;
        wdata_q    <= sel_we ? sel_wdata : '0;
        aw_valid_q <= sel_we;
        w_valid_q  <= sel_we;
        ar_valid_q <= ~sel_we;
      end else begin
        if (aw_valid_q && M_AXI_AWREADY) aw_valid_q <= 1'b0;
        if (w_valid_q && M_AXI_WREADY)   w_valid_q  <= 1'b0;
        if (ar_valid_q && M_AXI_ARREADY) ar_valid_q <= 1'b0;
      end
      // Response fields persist until the next completion so requesters may sample late.
      if (state == WR_B && M_AXI_BVALID) begin
        rsp_rdata_q <= '0;
        rsp_resp_q  <= M_AXI_BRESP;
      end else if (state == RD_R && M_AXI_RVALID) begin
        rsp_rdata_q <= M_AXI_RDATA;
        rsp_resp_q  <= M_AXI_RRESP;
      end
    end
  end

  assign RSP_RDATA     = rsp_rdata_q;
  assign RSP_RESP      = rsp_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = aw_valid_q;
  assign M_AXI_WVALID  = w_valid_q;
  assign M_AXI_ARVALID = ar_valid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign dbg_state     = state;

endmodule

// File: tb/tb_axil_reg_access_arbiter.sv
// Bench for axil_reg_access_arbiter: two requester drivers, a small AXI4-Lite register slave
// and a per-requester response scoreboard.
module tb_axil_reg_access_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rv[2];
  logic          rwe[2];
  logic [AW-1:0] raddr[2];
  logic [DW-1:0] rwd[2];

  logic [1:0]      req_valid, req_ready, req_we, rsp_valid, rsp_resp;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata;
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot, dbg_state;
  logic            awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] wstrb;
  logic            s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]      s_bresp, s_rresp;
  logic [DW-1:0]   s_rdata;

  assign req_valid = {rv[1], rv[0]};
  assign req_we    = {rwe[1], rwe[0]};
  assign req_addr  = {raddr[1], raddr[0]};
  assign req_wdata = {rwd[1], rwd[0]};

  axil_reg_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_RESP(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(s_awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(s_wready),
    .M_AXI_BRESP(s_bresp), .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(s_arready),
    .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(s_rvalid), .M_AXI_RREADY(rready),
    .dbg_state(dbg_state)
  );

  // ---------------- slave model ----------------
  int            aw_delay = 0;
  int            aw_cnt;
  logic          ar_hold = 1'b0;
  logic [1:0]    rresp_cfg = 2'b00;
  logic [DW-1:0] mem[4];
  logic          got_aw, got_w, aw_hs, w_hs;
  logic [AW-1:0] lat_addr, wa;
  logic [DW-1:0] lat_data, wdv;
  int            wr_count = 0;
  int            rd_count = 0;

  assign s_awready = (aw_cnt >= aw_delay);
  assign s_wready  = 1'b1;
  assign s_arready = !ar_hold;
  assign aw_hs     = awvalid & s_awready;
  assign w_hs      = wvalid & s_wready;
  assign wa        = aw_hs ? awaddr : lat_addr;
  assign wdv       = w_hs ? m_wdata : lat_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      lat_addr <= '0; lat_data <= '0;
      s_bvalid <= 1'b0; s_bresp <= 2'b00;
      s_rvalid <= 1'b0; s_rresp <= 2'b00; s_rdata <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (awvalid && !s_awready) aw_cnt <= aw_cnt + 1;
      else if (aw_hs)            aw_cnt <= 0;
      if (aw_hs) begin got_aw <= 1'b1; lat_addr <= awaddr; end
      if (w_hs)  begin got_w  <= 1'b1; lat_data <= m_wdata; end
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        mem[wa[3:2]] <= wdv;
        s_bvalid <= 1'b1;
        s_bresp  <= 2'b00;
        got_aw   <= 1'b0;
        got_w    <= 1'b0;
        wr_count <= wr_count + 1;
      end else if (s_bvalid && bready) begin
        s_bvalid <= 1'b0;
      end
      if (arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[araddr[3:2]];
        s_rresp  <= rresp_cfg;
        rd_count <= rd_count + 1;
      end else if (s_rvalid && rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  logic        gnt_log[$];
  logic [1:0]  prev_rsp = 2'b00;
  int          aw_hi = 0;
  int          w_hi = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready != 2'b00) begin
        check("req_ready_onehot", 64'($countones(req_ready)), 64'd1);
        gnt_log.push_back(req_ready[1]);
      end
      if (rsp_valid != 2'b00) begin
        check("rsp_pulse_width", {62'd0, prev_rsp}, 64'd0);
        if (rsp_valid[0]) begin
          if (exp_q0.size() == 0) check("rsp0_unexpected", 64'd1, 64'd0);
          else begin
            logic [33:0] e;
            e = exp_q0.pop_front();
            check("rsp0_rdata", {32'd0, rsp_rdata}, {32'd0, e[31:0]});
            check("rsp0_resp", {62'd0, rsp_resp}, {62'd0, e[33:32]});
          end
        end
        if (rsp_valid[1]) begin
          if (exp_q1.size() == 0) check("rsp1_unexpected", 64'd1, 64'd0);
          else begin
            logic [33:0] e;
            e = exp_q1.pop_front();
            check("rsp1_rdata", {32'd0, rsp_rdata}, {32'd0, e[31:0]});
            check("rsp1_resp", {62'd0, rsp_resp}, {62'd0, e[33:32]});
          end
        end
      end
      prev_rsp = rsp_valid;
      if (awvalid) aw_hi++;
      if (wvalid)  w_hi++;
    end else begin
      prev_rsp = 2'b00;
    end
  end

  // ---------------- driver ----------------
  // exp_lat > 0: also wait for the response and check grant-to-response latency.
  task automatic do_req(input int n, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [33:0] exp_rsp, input int exp_lat);
    int  k;
    logic got;
    @(posedge clk); #1;
    rv[n] = 1'b1; rwe[n] = we; raddr[n] = addr; rwd[n] = wd;
    if (n == 0) exp_q0.push_back(exp_rsp);
    else        exp_q1.push_back(exp_rsp);
    got = 1'b0;
    k = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      got = req_ready[n];
      k++;
    end
    if (!got) begin
      check("req_ready_timeout", 64'd0, 64'd1);
      rv[n] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    rv[n] = 1'b0; rwe[n] = 1'($urandom_range(0, 1));
    raddr[n] = 4'($urandom_range(0, 15)); rwd[n] = $urandom;
    if (exp_lat > 0) begin
      got = 1'b0;
      k = 0;
      while (!got && k < 200) begin
        @(negedge clk);
        k++;
        got = rsp_valid[n];
      end
      if (!got) check("rsp_timeout", 64'd0, 64'd1);
      else      check("grant_to_rsp_latency", 64'(k), 64'(exp_lat));
    end
  endtask

  task automatic drain();
    repeat (12) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wr_b, rd_b;
    logic got;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = '0; rwd[i] = '0;
    end

    // reset state
    #2;
    check("rst_state", {61'd0, dbg_state}, 64'd0);
    check("rst_valids", {59'd0, awvalid, wvalid, arvalid, bready, rready}, 64'd0);
    check("rst_rsp", {62'd0, rsp_valid}, 64'd0);
    check("rst_wstrb", {60'd0, wstrb}, 64'hf);
    check("rst_prot", {58'd0, awprot, arprot}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", {62'd0, req_ready}, 64'd0);

    // 1: req0 writes then reads back four registers
    for (int i = 0; i < 4; i++)
      do_req(0, 1'b1, 4'(i * 4), 32'(i + 1), 34'd0, 3);
    for (int i = 0; i < 4; i++)
      do_req(0, 1'b0, 4'(i * 4), 32'd0, {2'b00, 32'(i + 1)}, 3);
    drain();

    // 2: both requesters continuously requesting -> strict alternation
    gnt_log.delete();
    fork
      for (int i = 0; i < 4; i++) do_req(0, 1'b1, 4'h0, $urandom, 34'd0, 0);
      for (int i = 0; i < 4; i++) do_req(1, 1'b1, 4'hC, $urandom, 34'd0, 0);
    join
    drain();
    check("rr_grant_count", 64'(gnt_log.size()), 64'd8);
    for (int i = 0; i < gnt_log.size() && i < 8; i++)
      check("rr_grant_order", {63'd0, gnt_log[i]}, (i % 2 == 0) ? 64'd1 : 64'd0);

    // 3: AWREADY delayed 3 cycles, WREADY immediate
    aw_delay = 3;
    @(posedge clk); #1;
    aw_hi = 0; w_hi = 0; wr_b = wr_count;
    do_req(0, 1'b1, 4'h4, 32'hA5A5_0001, 34'd0, 6);
    check("aw_valid_cycles", 64'(aw_hi), 64'd4);
    check("w_valid_cycles", 64'(w_hi), 64'd1);
    check("slave_write_count", 64'(wr_count - wr_b), 64'd1);
    aw_delay = 0;
    drain();

    // 4: read with SLVERR passes through
    rresp_cfg = 2'b10;
    do_req(0, 1'b0, 4'h8, 32'd0, {2'b10, 32'd3}, 3);
    @(negedge clk);
    check("slverr_back_to_idle", {61'd0, dbg_state}, 64'd0);
    rresp_cfg = 2'b00;
    drain();

    // 5: reset while ARVALID stalls; afterwards req0 wins a tie
    ar_hold = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 4'h0;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = req_ready[0];
    end
    check("stall_read_granted", {63'd0, got}, 64'd1);
    @(posedge clk); #1 rv[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("arvalid_stalled", {63'd0, arvalid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arvalid_async_clear", {63'd0, arvalid}, 64'd0);
    check("state_async_idle", {61'd0, dbg_state}, 64'd0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    ar_hold = 1'b0;
    gnt_log.delete();
    fork
      do_req(0, 1'b1, 4'h0, 32'h11, 34'd0, 0);
      do_req(1, 1'b1, 4'h4, 32'h22, 34'd0, 0);
    join
    drain();
    check("post_rst_grants", 64'(gnt_log.size()), 64'd2);
    if (gnt_log.size() > 0) check("post_rst_first_grant", {63'd0, gnt_log[0]}, 64'd0);

    // 6: req1 pulses REQ_VALID for one cycle while req0 is busy
    gnt_log.delete();
    wr_b = wr_count; rd_b = rd_count;
    fork
      do_req(0, 1'b1, 4'h0, 32'h66, 34'd0, 3);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        rv[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 4'h4;
        @(posedge clk); #1;
        rv[1] = 1'b0;
      end
    join
    drain();
    check("drop_grant_count", 64'(gnt_log.size()), 64'd1);
    check("drop_writes", 64'(wr_count - wr_b), 64'd1);
    check("drop_reads", 64'(rd_count - rd_b), 64'd0);

    check("exp_q0_empty", 64'(exp_q0.size()), 64'd0);
    check("exp_q1_empty", 64'(exp_q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
